// File: rtl/adc_emulator_pkg.sv
// Shared constants for the ADC emulator: sample width, saturation limits,
// pattern encodings and triangle-engine direction values.
package adc_emulator_pkg;

    localparam int unsigned ADC_W = 14;
    localparam int unsigned SUM_W = ADC_W + 1;

    localparam logic signed [ADC_W-1:0] ADC_MAX = 14'sh1FFF;
    localparam logic signed [ADC_W-1:0] ADC_MIN = 14'sh2000;

    localparam logic [1:0] MODE_CONST    = 2'd0;
    localparam logic [1:0] MODE_RAMP     = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [1:0] MODE_SQUARE   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/adc_emulator_sat_add14.sv
// Saturates a signed 15-bit sum into the 14-bit two's-complement sample range.
module sat_add14
    import adc_emulator_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [ADC_W-1:0] result,
    output logic                    overflow
);

    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(ADC_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(ADC_MIN);

    always_comb begin
        result   = sum[ADC_W-1:0];
        overflow = 1'b0;
        if (sum > SUM_MAX) begin
            result   = ADC_MAX;
            overflow = 1'b1;
        end else if (sum < SUM_MIN) begin
            result   = ADC_MIN;
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/adc_emulator.sv
// Dual-channel 14-bit ADC emulator: DCO generator plus CONST/RAMP/TRIANGLE/SQUARE
// pattern engine; samples change only on DCO falling edges.
module adc_emulator
    import adc_emulator_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_RESET,
    input  logic                    i_enable,
    input  logic [1:0]              i_mode,
    input  logic [7:0]              i_div,
    input  logic [12:0]             i_step,
    input  logic [12:0]             i_amplitude,
    input  logic signed [ADC_W-1:0] i_offset,
    output logic signed [ADC_W-1:0] o_ADA_DATA,
    output logic signed [ADC_W-1:0] o_ADB_DATA,
    output logic                    o_ADA_OR,
    output logic                    o_ADB_OR,
    output logic                    o_DCO,
    output logic                    o_sample_tick
);

    logic [7:0]              cnt;
    logic [7:0]              div_eff;
    logic                    terminal;
    logic signed [ADC_W-1:0] acc;
    logic                    dir;
    logic [1:0]              mode_q;

    logic                    mode_change;
    logic signed [ADC_W-1:0] acc_base, acc_next, tri_acc, ramp_acc, ramp_b;
    logic                    dir_base, dir_next, tri_dir;
    logic signed [SUM_W-1:0] acc_wide, step_wide, amp_wide, up_sum, dn_sum, tri_wide;
    logic signed [SUM_W-1:0] off_wide, raw_a, raw_b, sum_a, sum_b;
    logic signed [ADC_W-1:0] sat_a, sat_b;
    logic                    ovf_a, ovf_b;

    // Half-period counter; >= keeps a shrinking divider from running past terminal.
    always_comb begin
        div_eff  = (i_div == 8'd0) ? 8'd1 : i_div;
        terminal = (cnt >= div_eff - 8'd1);
    end

    // Next sample: a mode change restarts the engine from acc=0, dir=up on this edge.
    always_comb begin
        mode_change = (i_mode != mode_q);
        acc_base    = mode_change ? '0 : acc;
        dir_base    = mode_change ? DIR_UP : dir;
        acc_wide    = SUM_W'(acc_base);
        step_wide   = SUM_W'(i_step);
        amp_wide    = SUM_W'(i_amplitude);
        off_wide    = SUM_W'(i_offset);
        up_sum      = acc_wide + step_wide;
        dn_sum      = acc_wide - step_wide;

        ramp_acc    = ADC_W'(up_sum);
        ramp_b      = {~ramp_acc[ADC_W-1], ramp_acc[ADC_W-2:0]};

        tri_acc     = acc_base;
        tri_dir     = dir_base;
        if (dir_base == DIR_UP) begin
            if (up_sum >= amp_wide) begin
                tri_acc = ADC_W'(amp_wide);
                tri_dir = DIR_DOWN;
            end else begin
                tri_acc = ADC_W'(up_sum);
            end
        end else begin
            if (dn_sum <= -amp_wide) begin
                tri_acc = ADC_W'(-amp_wide);
                tri_dir = DIR_UP;
            end else begin
                tri_acc = ADC_W'(dn_sum);
            end
        end
        tri_wide = SUM_W'(tri_acc);

        acc_next = acc_base;
        dir_next = dir_base;
        raw_a    = '0;
        raw_b    = '0;
        case (i_mode)
            MODE_RAMP: begin
                acc_next = ramp_acc;
                raw_a    = SUM_W'(ramp_acc);
                raw_b    = SUM_W'(ramp_b);
            end
            MODE_TRIANGLE: begin
                acc_next = tri_acc;
                dir_next = tri_dir;
                raw_a    = tri_wide;
                raw_b    = -tri_wide;
            end
            MODE_SQUARE: begin
                acc_next = tri_acc;
                dir_next = tri_dir;
                raw_a    = (tri_dir == DIR_UP) ? amp_wide : -amp_wide;
                raw_b    = tri_wide;
            end
            default: ;
        endcase

        sum_a = raw_a + off_wide;
        sum_b = raw_b + off_wide;
    end

    sat_add14 u_sat_a (.sum(sum_a), .result(sat_a), .overflow(ovf_a));
    sat_add14 u_sat_b (.sum(sum_b), .result(sat_b), .overflow(ovf_b));

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            cnt           <= '0;
            o_DCO         <= 1'b0;
            o_sample_tick <= 1'b0;
            o_ADA_DATA    <= '0;
            o_ADB_DATA    <= '0;
            o_ADA_OR      <= 1'b0;
            o_ADB_OR      <= 1'b0;
            acc           <= '0;
            dir           <= DIR_UP;
            mode_q        <= MODE_CONST;
        end else if (!i_enable) begin
            cnt           <= '0;
            o_DCO         <= 1'b0;
            o_sample_tick <= 1'b0;
        end else if (terminal) begin
            cnt           <= '0;
            o_DCO         <= ~o_DCO;
            o_sample_tick <= o_DCO;
            // Update only as DCO falls, centring data on the DCO rising edge.
            if (o_DCO) begin
                acc        <= acc_next;
                dir        <= dir_next;
                mode_q     <= i_mode;
                o_ADA_DATA <= sat_a;
                o_ADB_DATA <= sat_b;
                o_ADA_OR   <= ovf_a;
                o_ADB_OR   <= ovf_b;
            end
        end else begin
            cnt           <= cnt + 8'd1;
            o_sample_tick <= 1'b0;
        end
    end

endmodule
